bht_upd_ctrl: RTL and testbench

Retire-side update controller for the gshare branch history table. Accepts up to two retiring conditional-branch outcomes per cycle from the ROB, computes each pattern-table index, buffers them in a small FIFO, and drains one update per cycle to the table's single counter-update port. It also sequences a table-clear walk after reset or on request, during which prediction reads are blocked.

---
 rtl/bht_upd_ctrl_pkg.sv | 22 ++
 rtl/bht_upd_fifo.sv | 73 +++++++
 rtl/bht_upd_ctrl.sv | 159 +++++++++++++++
 tb/tb_bht_upd_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bht_upd_ctrl_pkg.sv
// Shared types and constants for the gshare BHT retire-side update controller.
// The clear walk writes WK_NOT_TAKEN into every pattern-table counter.
package bht_upd_ctrl_pkg;

  localparam int BIT_BHT   = 6;
  localparam int LEN_BHT   = 1 << BIT_BHT;
  localparam int UPD_DEPTH = 8;
  localparam int ENTRY_W   = BIT_BHT + 1;

  typedef enum logic [1:0] {
    ST_NOT_TAKEN = 2'b00,
    WK_NOT_TAKEN = 2'b01,
    WK_TAKEN     = 2'b10,
    ST_TAKEN     = 2'b11
  } bht_ctr_e;

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_RUN   = 1'b1
  } upd_state_e;

endpackage

// File: rtl/bht_upd_fifo.sv
// Two-push / one-pop update FIFO with occupancy count and synchronous flush.
// Pushes that find no room are dropped; a push arriving while the FIFO is full is a protocol error.
module bht_upd_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 7
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   i_flush,
  input  logic                   i_push_a,
  input  logic [W-1:0]           i_data_a,
  input  logic                   i_push_b,
  input  logic [W-1:0]           i_data_b,
  input  logic                   i_pop,
  output logic [W-1:0]           o_head,
  output logic [$clog2(DEPTH):0] o_count,
  output logic [$clog2(DEPTH):0] o_count_next
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;

  logic          w_acc_a;
  logic          w_acc_b;
  logic          w_pop;
  logic [CW-1:0] w_count_next;

  assign w_acc_a      = i_push_a && (r_count < DEPTH_C);
  assign w_acc_b      = i_push_b && ((r_count + CW'(w_acc_a)) < DEPTH_C);
  assign w_pop        = i_pop && (r_count != '0);
  assign w_count_next = i_flush ? '0
                      : r_count + CW'(w_acc_a) + CW'(w_acc_b) - CW'(w_pop);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + PW'(w_acc_a) + PW'(w_acc_b);
      r_rd_ptr <= r_rd_ptr + PW'(w_pop);
      r_count  <= w_count_next;
    end
  end

  // Slot b lands right behind slot a when both are accepted.
  always_ff @(posedge clock) begin
    if (!i_flush) begin
      if (w_acc_a) r_mem[r_wr_ptr] <= i_data_a;
      if (w_acc_b) r_mem[r_wr_ptr + PW'(w_acc_a)] <= i_data_b;
    end
  end

  assign o_head       = r_mem[r_rd_ptr];
  assign o_count      = r_count;
  assign o_count_next = w_count_next;

`ifndef SYNTHESIS
  a_no_overflow: assert property (@(posedge clock) disable iff (reset)
    !i_flush |-> ((i_push_a == w_acc_a) && (i_push_b == w_acc_b)));
`endif

endmodule

// File: rtl/bht_upd_ctrl.sv
// Retire-side gshare BHT update controller: index hash, update FIFO, clear-walk FSM, retire stall.
// Optional BHT_UPD_BYPASS_EN: with the FIFO empty in RUN, the first retiring update drives upd_* in its retire cycle.
module bht_upd_ctrl #(
  parameter int DEPTH   = 8,
  parameter int BIT_BHT = 6
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [1:0]         rob_retire_num,
  input  logic               rob_retire_cond0,
  input  logic               rob_retire_cond1,
  input  logic [63:0]        rob_retire_NPC0,
  input  logic [63:0]        rob_retire_NPC1,
  input  logic [BIT_BHT-1:0] rob_retire_BHR0,
  input  logic [BIT_BHT-1:0] rob_retire_BHR1,
  input  logic               rob_actual_taken0,
  input  logic               rob_actual_taken1,
  input  logic               clear_req,
  output logic               upd_valid,
  output logic [BIT_BHT-1:0] upd_idx,
  output logic               upd_taken,
  output logic               clr_valid,
  output logic [BIT_BHT-1:0] clr_idx,
  output logic               pred_block,
  output logic               rob_retire_stall
);

  import bht_upd_ctrl_pkg::*;

  // state   | meaning
  // S_CLEAR | walking clr_idx over the table, predictions blocked, retires dropped
  // S_RUN   | draining queued retire updates one per cycle

  localparam int EW = BIT_BHT + 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [BIT_BHT-1:0] LAST_IDX = '1;
  localparam logic [CW-1:0]      STALL_TH = CW'(DEPTH - 2);

  upd_state_e         r_state;
  logic [BIT_BHT-1:0] r_clr_idx;
  logic               r_clr_valid;
  logic               r_pred_block;
  logic               r_stall;

  logic               w_run;
  logic               w_v0;
  logic               w_v1;
  logic [EW-1:0]      w_e0;
  logic [EW-1:0]      w_e1;
  logic               w_first_v;
  logic [EW-1:0]      w_first_e;
  logic               w_second_v;
  logic               w_byp;
  logic [EW-1:0]      w_byp_e;
  logic               w_push_a;
  logic [EW-1:0]      w_data_a;
  logic               w_push_b;
  logic               w_flush;
  logic               w_pop;
  logic               w_head_v;
  logic [EW-1:0]      w_head;
  logic [EW-1:0]      w_out_e;
  logic [CW-1:0]      w_count;
  logic [CW-1:0]      w_count_next;
  logic               w_unused_npc;

  assign w_run = (r_state == S_RUN);

  // Slot 1 retires only when two instructions retire (num 2 or 3).
  assign w_v0 = (rob_retire_num != 2'd0) && rob_retire_cond0;
  assign w_v1 = rob_retire_num[1] && rob_retire_cond1;
  assign w_e0 = {rob_retire_NPC0[BIT_BHT+1:2] ^ rob_retire_BHR0, rob_actual_taken0};
  assign w_e1 = {rob_retire_NPC1[BIT_BHT+1:2] ^ rob_retire_BHR1, rob_actual_taken1};

  assign w_unused_npc = ^{rob_retire_NPC0[63:BIT_BHT+2], rob_retire_NPC0[1:0],
                          rob_retire_NPC1[63:BIT_BHT+2], rob_retire_NPC1[1:0]};

  assign w_first_v  = w_v0 || w_v1;
  assign w_first_e  = w_v0 ? w_e0 : w_e1;
  assign w_second_v = w_v0 && w_v1;

`ifdef BHT_UPD_BYPASS_EN
  assign w_byp   = w_run && (w_count == '0) && w_first_v;
  assign w_byp_e = w_first_e;
`else
  assign w_byp   = 1'b0;
  assign w_byp_e = '0;
`endif

  assign w_push_a = w_run && (w_byp ? w_second_v : w_first_v);
  assign w_data_a = w_byp ? w_e1 : w_first_e;
  assign w_push_b = w_run && !w_byp && w_second_v;
  assign w_flush  = !w_run || clear_req;
  assign w_head_v = w_run && (w_count != '0);
  assign w_pop    = w_head_v;

  bht_upd_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clock        (clock),
    .reset        (reset),
    .i_flush      (w_flush),
    .i_push_a     (w_push_a),
    .i_data_a     (w_data_a),
    .i_push_b     (w_push_b),
    .i_data_b     (w_e1),
    .i_pop        (w_pop),
    .o_head       (w_head),
    .o_count      (w_count),
    .o_count_next (w_count_next)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= S_CLEAR;
      r_clr_idx    <= '0;
      r_clr_valid  <= 1'b1;
      r_pred_block <= 1'b1;
      r_stall      <= 1'b0;
    end else begin
      r_stall <= (w_count_next > STALL_TH);
      case (r_state)
        S_CLEAR: begin
          if (clear_req) begin
            r_clr_idx <= '0;
          end else if (r_clr_idx == LAST_IDX) begin
            r_state      <= S_RUN;
            r_clr_idx    <= '0;
            r_clr_valid  <= 1'b0;
            r_pred_block <= 1'b0;
          end else begin
            r_clr_idx <= r_clr_idx + 1'b1;
          end
        end
        S_RUN: begin
          if (clear_req) begin
            r_state      <= S_CLEAR;
            r_clr_idx    <= '0;
            r_clr_valid  <= 1'b1;
            r_pred_block <= 1'b1;
          end
        end
        default: r_state <= S_CLEAR;
      endcase
    end
  end

  assign w_out_e = w_head_v ? w_head : (w_byp ? w_byp_e : '0);

  assign upd_valid        = w_head_v || w_byp;
  assign upd_idx          = w_out_e[EW-1:1];
  assign upd_taken        = w_out_e[0];
  assign clr_valid        = r_clr_valid;
  assign clr_idx          = r_clr_idx;
  assign pred_block       = r_pred_block;
  assign rob_retire_stall = r_stall;

endmodule

// File: tb/tb_bht_upd_ctrl.sv
// Randomized self-checking bench for bht_upd_ctrl against a queue-based reference model.
// Build with BHT_UPD_BYPASS_EN defined to check the bypass variant.
module tb_bht_upd_ctrl;

  localparam int DEPTH = 8;
  localparam int BB    = 6;
  localparam int LEN   = 1 << BB;

  logic          clock;
  logic          reset;
  logic [1:0]    rob_retire_num;
  logic          rob_retire_cond0, rob_retire_cond1;
  logic [63:0]   rob_retire_NPC0, rob_retire_NPC1;
  logic [BB-1:0] rob_retire_BHR0, rob_retire_BHR1;
  logic          rob_actual_taken0, rob_actual_taken1;
  logic          clear_req;
  logic          upd_valid;
  logic [BB-1:0] upd_idx;
  logic          upd_taken;
  logic          clr_valid;
  logic [BB-1:0] clr_idx;
  logic          pred_block;
  logic          rob_retire_stall;

  bht_upd_ctrl #(.DEPTH(DEPTH), .BIT_BHT(BB)) dut (
    .clock             (clock),
    .reset             (reset),
    .rob_retire_num    (rob_retire_num),
    .rob_retire_cond0  (rob_retire_cond0),
    .rob_retire_cond1  (rob_retire_cond1),
    .rob_retire_NPC0   (rob_retire_NPC0),
    .rob_retire_NPC1   (rob_retire_NPC1),
    .rob_retire_BHR0   (rob_retire_BHR0),
    .rob_retire_BHR1   (rob_retire_BHR1),
    .rob_actual_taken0 (rob_actual_taken0),
    .rob_actual_taken1 (rob_actual_taken1),
    .clear_req         (clear_req),
    .upd_valid         (upd_valid),
    .upd_idx           (upd_idx),
    .upd_taken         (upd_taken),
    .clr_valid         (clr_valid),
    .clr_idx           (clr_idx),
    .pred_block        (pred_block),
    .rob_retire_stall  (rob_retire_stall)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: table-clear walk position plus a queue of pending {idx,taken} updates.
  bit m_clear = 1'b1;
  int m_walk  = 0;
  int m_q[$];
  bit m_stall = 1'b0;
`ifdef BHT_UPD_BYPASS_EN
  bit m_byp = 1'b1;
`else
  bit m_byp = 1'b0;
`endif

  int n_upd = 0;
  int n_acc = 0;
  int n_stall = 0;
  bit obs_v;
  int obs_e;

  function automatic int entry_of(input logic [63:0] npc, input logic [BB-1:0] bhr, input logic t);
    int idx;
    idx = int'((npc >> 2) % LEN) ^ int'(bhr);
    return idx * 2 + int'(t);
  endfunction

  task automatic drive(input int num, input bit c0, input bit c1,
                       input logic [63:0] n0, input int b0, input bit t0,
                       input logic [63:0] n1, input int b1, input bit t1, input bit creq);
    rob_retire_num    = 2'(num);
    rob_retire_cond0  = c0;
    rob_retire_cond1  = c1;
    rob_retire_NPC0   = n0;
    rob_retire_BHR0   = BB'(b0);
    rob_actual_taken0 = t0;
    rob_retire_NPC1   = n1;
    rob_retire_BHR1   = BB'(b1);
    rob_actual_taken1 = t1;
    clear_req         = creq;
  endtask

  task automatic idle();
    drive(0, 0, 0, 64'h0, 0, 0, 64'h0, 0, 0, 0);
  endtask

  task automatic rand_drive(input bit allow_clear);
    drive($urandom_range(0, 3), 1'($urandom), 1'($urandom),
          {$urandom, $urandom}, $urandom_range(0, LEN - 1), 1'($urandom),
          {$urandom, $urandom}, $urandom_range(0, LEN - 1), 1'($urandom),
          allow_clear && ($urandom_range(0, 299) == 0));
  endtask

  // One clock cycle: honour the stall, check outputs mid-cycle, then advance the model.
  task automatic step();
    int  lst[$];
    int  exp_e;
    bit  exp_v;
    if (m_stall) rob_retire_num = 2'd0;
    #1;
    if (rob_retire_num >= 2'd1 && rob_retire_cond0)
      lst.push_back(entry_of(rob_retire_NPC0, rob_retire_BHR0, rob_actual_taken0));
    if (rob_retire_num >= 2'd2 && rob_retire_cond1)
      lst.push_back(entry_of(rob_retire_NPC1, rob_retire_BHR1, rob_actual_taken1));
    obs_v = upd_valid;
    obs_e = int'({upd_idx, upd_taken});
    if (upd_valid) n_upd++;
    if (rob_retire_stall) n_stall++;
    check("clr_valid", clr_valid, m_clear);
    check("pred_block", pred_block, m_clear);
    check("stall", rob_retire_stall, m_stall);
    if (m_clear) begin
      check("clr_idx", clr_idx, m_walk);
      check("upd_valid_in_clear", upd_valid, 0);
      if (clear_req) m_walk = 0;
      else if (m_walk == LEN - 1) m_clear = 1'b0;
      else m_walk++;
    end else begin
      exp_v = 1'b0;
      exp_e = 0;
      if (m_q.size() > 0) begin
        exp_v = 1'b1;
        exp_e = m_q.pop_front();
      end else if (m_byp && lst.size() > 0) begin
        exp_v = 1'b1;
        exp_e = lst.pop_front();
      end
      check("upd_valid", upd_valid, exp_v);
      if (exp_v) check("upd_entry", obs_e, exp_e);
      if (clear_req) begin
        m_q.delete();
        m_clear = 1'b1;
        m_walk  = 0;
      end else begin
        foreach (lst[i]) m_q.push_back(lst[i]);
        n_acc += lst.size() + ((exp_v && m_byp && obs_v && m_q.size() == lst.size()) ? 0 : 0);
      end
    end
    m_stall = (m_q.size() > DEPTH - 2);
    @(negedge clock);
  endtask

  int acc0, upd0;

  initial begin
    idle();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check("rst_clr_valid", clr_valid, 1);
    check("rst_pred_block", pred_block, 1);
    check("rst_upd_valid", upd_valid, 0);
    check("rst_upd_idx", upd_idx, 0);
    check("rst_upd_taken", upd_taken, 0);
    check("rst_clr_idx", clr_idx, 0);
    check("rst_stall", rob_retire_stall, 0);
    reset = 1'b0;

    // Clear walk after reset, retires during the walk are dropped.
    for (int i = 0; i < LEN; i++) begin
      rand_drive(0);
      step();
    end
    idle();
    step();
    check("run_pred_block", pred_block, 0);

    // Two-slot hash example.
    drive(2, 1, 1, 64'h100, 'h05, 1, 64'h10C, 'h00, 0, 0);
    step();
`ifdef BHT_UPD_BYPASS_EN
    check("ex_slot0_same_cycle", obs_e, 'h05 * 2 + 1);
`endif
    idle();
    step();
`ifdef BHT_UPD_BYPASS_EN
    check("ex_slot1", obs_e, 'h03 * 2);
`else
    check("ex_slot0", obs_e, 'h05 * 2 + 1);
`endif
    step();
`ifndef BHT_UPD_BYPASS_EN
    check("ex_slot1", obs_e, 'h03 * 2);
`endif
    step();

    // Slot-1 qualification.
    drive(1, 0, 1, 64'h0, 0, 0, 64'h40, 3, 1, 0);
    step();
    idle();
    repeat (2) step();
    drive(2, 0, 1, 64'h0, 0, 0, 64'hFC, 1, 1, 0);
    step();
    idle();
    repeat (3) step();

    // Bypass / latency on a single update with idx 0x2A.
    drive(1, 1, 0, 64'hA8, 0, 1, 64'h0, 0, 0, 0);
    step();
`ifdef BHT_UPD_BYPASS_EN
    check("byp_valid", obs_v, 1);
    check("byp_entry", obs_e, 'h2A * 2 + 1);
`else
    check("nobyp_valid", obs_v, 0);
    idle();
    step();
    check("lat1_entry", obs_e, 'h2A * 2 + 1);
`endif
    idle();
    repeat (2) step();

    // Back-to-back double pushes until stall throttles, then drain.
    acc0 = n_acc;
    upd0 = n_upd;
    n_stall = 0;
    for (int i = 0; i < 8; i++) begin
      drive(2, 1, 1, {$urandom, $urandom}, $urandom_range(0, LEN - 1), 1'($urandom),
            {$urandom, $urandom}, $urandom_range(0, LEN - 1), 1'($urandom), 0);
      step();
    end
    idle();
    repeat (12) step();
    check("burst_stall_seen", n_stall > 0, 1);
    check("burst_drain_count", n_upd - upd0, n_acc - acc0);

    // Queue some entries, then request a clear; walk must emit no updates.
    for (int i = 0; i < 4; i++) begin
      drive(2, 1, 1, {$urandom, $urandom}, $urandom_range(0, LEN - 1), 1'($urandom),
            {$urandom, $urandom}, $urandom_range(0, LEN - 1), 1'($urandom), 0);
      step();
    end
    idle();
    clear_req = 1'b1;
    step();
    upd0 = n_upd;
    for (int i = 0; i < LEN; i++) begin
      rand_drive(0);
      step();
    end
    check("walk_no_updates", n_upd - upd0, 0);

    // Random traffic with occasional clears.
    for (int i = 0; i < 1500; i++) begin
      rand_drive(1);
      step();
    end
    idle();
    repeat (12) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
